// File: rtl/cdc_pulse_arbiter_if.sv
// Handshake bundle between event requesters, the pulse crossing and the arbiter.
// Ports: req/xfer_ack/clr_err in, xfer_pulse/xfer_id/busy/pend_ovf/timeout_err out.
interface cdc_pulse_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]    req;
  logic            xfer_ack;
  logic            clr_err;
  logic            xfer_pulse;
  logic [ID_W-1:0] xfer_id;
  logic            busy;
  logic [N-1:0]    pend_ovf;
  logic            timeout_err;

  modport master (
    output req, xfer_ack, clr_err,
    input  xfer_pulse, xfer_id, busy,
    input  pend_ovf, timeout_err
  );

  modport slave (
    input  req, xfer_ack, clr_err,
    output xfer_pulse, xfer_id, busy,
    output pend_ovf, timeout_err
  );
endinterface

// File: rtl/cdc_pulse_arbiter.sv
// Round-robin scheduler sharing one pulse CDC channel among N event sources.
// Ports: clk, rst (async high), bus (slave): req/ack/clr in, pulse/id/flags out.
module cdc_pulse_arbiter #(
  parameter  int N       = 4,
  parameter  int CNT_W   = 4,
  parameter  int GAP     = 2,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  cdc_pulse_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_WAIT, S_GAP
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // With GAP = 0 the spacing state is skipped entirely.
  localparam state_t S_AFTER = (GAP == 0) ? S_IDLE : S_GAP;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt [N];
  logic [N-1:0]    r_ovf;
  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] r_id;
  logic            r_pulse;
  logic            r_busy;
  logic            r_terr;
  logic [TW-1:0]   r_tmr;
  logic [7:0]      r_gcnt;

  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt;
  logic            w_take;
  logic [N-1:0]    w_dec;
  logic [N-1:0]    w_ovf_set;
  logic            w_expire;
  logic            w_gap_done;
  logic            w_to_err;
  logic [ID_W-1:0] w_rr_nxt;

  // Scan from the highest offset down so the lowest offset from r_rr wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(r_rr) + k) % N;
      if (r_cnt[idx] != '0) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'(idx);
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_gnt_vld;

  always_comb begin
    w_dec     = '0;
    w_ovf_set = '0;
    for (int i = 0; i < N; i++) begin
      w_dec[i]     = w_take && (w_gnt == ID_W'(i));
      w_ovf_set[i] = bus.req[i] && !w_dec[i] &&
                     (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_rr_nxt   = (w_gnt == ID_W'(N - 1)) ?
                      '0 : w_gnt + 1'b1;
  assign w_expire   = (TIMEOUT != 0) &&
                      (r_tmr == TW'(TIMEOUT - 1));
  assign w_gap_done = (r_gcnt == 8'(GAP - 1));
  // An ack in the expiry cycle takes precedence over the timeout.
  assign w_to_err   = (r_state == S_WAIT) &&
                      !bus.xfer_ack && w_expire;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_gnt_vld) w_state_nxt = S_SEND;
      S_SEND: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.xfer_ack || w_expire)
          w_state_nxt = S_AFTER;
      end
      S_GAP: if (w_gap_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_id    <= '0;
      r_rr    <= '0;
      r_terr  <= 1'b0;
      r_tmr   <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= (w_state_nxt == S_SEND);
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_take) begin
        r_id <= w_gnt;
        r_rr <= w_rr_nxt;
      end
      r_terr <= w_to_err | (r_terr & ~bus.clr_err);
      r_tmr  <= (r_state == S_WAIT) ? r_tmr + 1'b1 : '0;
      r_gcnt <= (r_state == S_GAP) ? r_gcnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && !w_dec[i]) begin
          if (r_cnt[i] != CNT_MAX)
            r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !bus.req[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
        r_ovf[i] <= w_ovf_set[i] |
                    (r_ovf[i] & ~bus.clr_err);
      end
    end
  end

  assign bus.xfer_pulse  = r_pulse;
  assign bus.xfer_id     = r_id;
  assign bus.busy        = r_busy;
  assign bus.pend_ovf    = r_ovf;
  assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Directed bench for cdc_pulse_arbiter: instance a (TIMEOUT=8), b (TIMEOUT=0).
// Inputs are driven and outputs observed on the falling clock edge.
module tb_cdc_pulse_arbiter;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad   = 0;
  int np_a  = 0;
  int np_b  = 0;
  int ids_a[$];
  int ids_b[$];
  int base;
  int nbad;

  cdc_pulse_arbiter_if #(.N(4)) bus_a ();
  cdc_pulse_arbiter_if #(.N(4)) bus_b ();

  cdc_pulse_arbiter #(
    .N(4), .CNT_W(4), .GAP(2), .TIMEOUT(8)
  ) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  cdc_pulse_arbiter #(
    .N(4), .CNT_W(4), .GAP(2), .TIMEOUT(0)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_a.xfer_pulse) begin
      np_a++;
      ids_a.push_back(int'(bus_a.xfer_id));
    end
    if (bus_b.xfer_pulse) begin
      np_b++;
      ids_b.push_back(int'(bus_b.xfer_id));
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.req = '0; bus_a.xfer_ack = 0; bus_a.clr_err = 0;
    bus_b.req = '0; bus_b.xfer_ack = 0; bus_b.clr_err = 0;
    tick();
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_pulse", bus_a.xfer_pulse, 0);
    chk("rst_id", bus_a.xfer_id, 0);
    chk("rst_ovf", bus_a.pend_ovf, 0);
    chk("rst_terr", bus_a.timeout_err, 0);
    rst = 1'b0;
    tick(); tick();

    // Round robin from pointer 0, ack held high.
    base = ids_a.size();
    bus_a.req = 4'b1111;
    tick();
    bus_a.req = '0;
    bus_a.xfer_ack = 1'b1;
    repeat (30) tick();
    bus_a.xfer_ack = 1'b0;
    chk("rr_count", ids_a.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (ids_a.size() > base + k)
        chk("rr_id", ids_a[base + k], k);
    chk("rr_busy", bus_a.busy, 0);

    // Single event on 2, ack three cycles after the pulse.
    tick();
    bus_a.req = 4'b0100;
    tick();
    bus_a.req = '0;
    chk("se_t1_pulse", bus_a.xfer_pulse, 0);
    tick();
    chk("se_t2_pulse", bus_a.xfer_pulse, 1);
    chk("se_t2_id", bus_a.xfer_id, 2);
    chk("se_t2_busy", bus_a.busy, 1);
    tick();
    chk("se_t3_pulse", bus_a.xfer_pulse, 0);
    chk("se_t3_id", bus_a.xfer_id, 2);
    tick();
    tick();
    bus_a.xfer_ack = 1'b1;
    tick();
    bus_a.xfer_ack = 1'b0;
    chk("se_gap1_busy", bus_a.busy, 1);
    tick();
    chk("se_gap2_busy", bus_a.busy, 1);
    tick();
    chk("se_idle_busy", bus_a.busy, 0);
    chk("se_cnt2", u_a.r_cnt[2], 0);
    chk("se_terr", bus_a.timeout_err, 0);
    chk("se_ovf", bus_a.pend_ovf, 0);

    // Timeout on requester 0, then 1 is served; ack on expiry cycle.
    bus_a.req = 4'b0011;
    tick();
    bus_a.req = '0;
    tick();
    chk("to_pulse0", bus_a.xfer_pulse, 1);
    chk("to_id0", bus_a.xfer_id, 0);
    repeat (8) tick();
    chk("to_t10_terr", bus_a.timeout_err, 0);
    tick();
    chk("to_t11_terr", bus_a.timeout_err, 1);
    chk("to_t11_busy", bus_a.busy, 1);
    tick();
    tick();
    chk("to_t13_busy", bus_a.busy, 0);
    tick();
    chk("to_pulse1", bus_a.xfer_pulse, 1);
    chk("to_id1", bus_a.xfer_id, 1);
    tick();
    bus_a.clr_err = 1'b1;
    tick();
    bus_a.clr_err = 1'b0;
    chk("to_clr", bus_a.timeout_err, 0);
    repeat (6) tick();
    bus_a.xfer_ack = 1'b1;
    tick();
    bus_a.xfer_ack = 1'b0;
    chk("co_terr", bus_a.timeout_err, 0);
    chk("co_busy", bus_a.busy, 1);
    tick();
    tick();
    chk("co_idle", bus_a.busy, 0);
    chk("co_terr2", bus_a.timeout_err, 0);

    // Stray ack while idle.
    base = ids_a.size();
    bus_a.xfer_ack = 1'b1;
    tick();
    bus_a.xfer_ack = 1'b0;
    chk("stray_busy", bus_a.busy, 0);
    tick();
    chk("stray_busy2", bus_a.busy, 0);
    chk("stray_np", ids_a.size() - base, 0);

    // Reset during WAIT_ACK with three events pending (rr now 2).
    bus_a.req = 4'b0100;
    tick();
    bus_a.req = '0;
    tick();
    chk("rm_pulse", bus_a.xfer_pulse, 1);
    chk("rm_id", bus_a.xfer_id, 2);
    bus_a.req = 4'b1011;
    tick();
    bus_a.req = '0;
    tick();
    chk("rm_pend0", u_a.r_cnt[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_busy", bus_a.busy, 0);
    chk("rm_id0", bus_a.xfer_id, 0);
    chk("rm_cnt", {u_a.r_cnt[3], u_a.r_cnt[1],
                   u_a.r_cnt[0]}, 0);
    chk("rm_terr", bus_a.timeout_err, 0);
    tick();
    rst = 1'b0;
    base = ids_a.size();
    repeat (20) tick();
    chk("rm_quiet_np", ids_a.size() - base, 0);
    chk("rm_quiet_busy", bus_a.busy, 0);
    bus_a.req = 4'b1000;
    tick();
    bus_a.req = '0;
    chk("rm_new_t1", bus_a.xfer_pulse, 0);
    tick();
    chk("rm_new_pulse", bus_a.xfer_pulse, 1);
    chk("rm_new_id", bus_a.xfer_id, 3);
    bus_a.xfer_ack = 1'b1;
    repeat (6) tick();
    bus_a.xfer_ack = 1'b0;

    // Saturation on b: req[1] held 20 cycles, no ack.
    base = ids_b.size();
    for (int c = 0; c < 20; c++) begin
      if (c == 16) begin
        chk("sat_cnt15", u_b.r_cnt[1], 15);
        chk("sat_ovf0", bus_b.pend_ovf, 0);
      end
      if (c == 17) begin
        chk("sat_ovf1", bus_b.pend_ovf, 4'b0010);
        bus_b.clr_err = 1'b1;
      end
      if (c == 18) begin
        bus_b.clr_err = 1'b0;
        chk("sat_setwins", bus_b.pend_ovf, 4'b0010);
      end
      bus_b.req = 4'b0010;
      tick();
    end
    bus_b.req = '0;
    chk("sat_np1", ids_b.size() - base, 1);
    chk("sat_hold", u_b.r_cnt[1], 15);
    bus_b.xfer_ack = 1'b1;
    repeat (100) tick();
    bus_b.xfer_ack = 1'b0;
    chk("sat_np16", ids_b.size() - base, 16);
    nbad = 0;
    for (int k = base; k < ids_b.size(); k++)
      if (ids_b[k] != 1) nbad++;
    chk("sat_ids", nbad, 0);
    chk("sat_busy", bus_b.busy, 0);
    chk("sat_cnt0", u_b.r_cnt[1], 0);
    chk("sat_ovf_kept", bus_b.pend_ovf, 4'b0010);
    bus_b.clr_err = 1'b1;
    tick();
    bus_b.clr_err = 1'b0;
    tick();
    chk("sat_clr", bus_b.pend_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
